// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, 8N1 LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 10_000_000,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wr_en,
   input  logic [7:0]                  wr_data,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(FIFO_DEPTH):0] count,
   output logic                        overflow,
   output logic                        tx_busy,
   output logic                        tx
);

   localparam int DIVISOR = CLK_FREQ / BAUD;
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int CW      = AW + 1;
   localparam int BW      = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(DIVISOR - 1);

   if (DIVISOR < 2) begin : g_div_chk
      $error("uart_tx_fifo: CLK_FREQ/BAUD must be >= 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
   end

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t          state, state_d;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count_d;
   logic [BW-1:0]   baud_cnt, baud_d;
   logic [2:0]      bit_idx, bit_d;
   logic [7:0]      shift, shift_d;
   logic            tx_d;
   logic            push, pop, bit_done;

   assign push     = wr_en && !full;
   assign pop      = (state == IDLE) && !empty;
   assign bit_done = (baud_cnt == BAUD_LAST);
   assign tx_busy  = (state != IDLE);

   always_comb begin
      count_d = count;
      unique case ({push, pop})
         2'b10:   count_d = count + 1'b1;
         2'b01:   count_d = count - 1'b1;
         default: count_d = count;
      endcase
   end

   // full/empty are registered from next occupancy so they settle at the push edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count    <= count_d;
         full     <= (count_d == CW'(FIFO_DEPTH));
         empty    <= (count_d == '0);
         overflow <= wr_en && full;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

`ifdef UART_TX_PARITY_EN
   logic par_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   par_q <= 1'b0;
      else if (pop) par_q <= ^mem[rd_ptr];
   end
`endif

   always_comb begin
      state_d = state;
      baud_d  = baud_cnt;
      bit_d   = bit_idx;
      shift_d = shift;
      tx_d    = 1'b1;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               state_d = START;
               baud_d  = '0;
               shift_d = mem[rd_ptr];
            end
         end
         START: begin
            baud_d = bit_done ? '0 : baud_cnt + 1'b1;
            if (bit_done) begin
               state_d = DATA;
               bit_d   = 3'd0;
            end
         end
         DATA: begin
            baud_d = bit_done ? '0 : baud_cnt + 1'b1;
            if (bit_done) begin
               shift_d = {1'b0, shift[7:1]};
               bit_d   = bit_idx + 3'd1;
`ifdef UART_TX_PARITY_EN
               if (bit_idx == 3'd7) state_d = PARITY;
`else
               if (bit_idx == 3'd7) state_d = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            baud_d = bit_done ? '0 : baud_cnt + 1'b1;
            if (bit_done) state_d = STOP;
         end
`endif
         STOP: begin
            baud_d = bit_done ? '0 : baud_cnt + 1'b1;
            if (bit_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // line level follows the state being entered, so tx is a clean register
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = par_q;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_d;
         baud_cnt <= baud_d;
         bit_idx  <= bit_d;
         shift    <= shift_d;
         tx       <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo at DIVISOR=4.
// Frame decoder pops expected bytes; scenario tasks check timing inline.
module tb_uart_tx_fifo;

   localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * DIV;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       full, empty, overflow, tx_busy, tx;
   logic [3:0] count;

   int checks = 0;
   int errors = 0;
   int frames_rx = 0;
   logic [7:0] sb [$];

   uart_tx_fifo #(
      .CLK_FREQ   (1_000_000),
      .BAUD       (250_000),
      .FIFO_DEPTH (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow),
      .tx_busy  (tx_busy),
      .tx       (tx)
   );

   always #5 clk = ~clk;

   function automatic logic tx_expect(input logic [7:0] d, input int c);
      if (c <= DIV) return 1'b0;
      if (c <= 9 * DIV) return d[(c - DIV - 1) / DIV];
`ifdef UART_TX_PARITY_EN
      if (c <= 10 * DIV) return ^d;
`endif
      return 1'b1;
   endfunction

   // frame decoder: samples the middle of each bit, compares against scoreboard
   initial begin
      int         pos;
      logic       prev;
      logic [7:0] rx;
      logic       par_ok;
      logic [7:0] exp_b;
      pos = -1;
      prev = 1'b1;
      rx = 8'h00;
      par_ok = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pos = -1;
            prev = 1'b1;
         end else if (pos < 0) begin
            if (tx === 1'b0 && prev === 1'b1) begin
               pos = 0;
               par_ok = 1'b1;
            end
            prev = tx;
         end else begin
            pos++;
            if (pos == 2 && tx !== 1'b0) begin
               pos = -1;
               prev = tx;
            end else if (pos >= 6 && pos <= 34 && (pos % DIV) == 2) begin
               rx[pos / DIV - 1] = tx;
`ifdef UART_TX_PARITY_EN
            end else if (pos == 9 * DIV + 2) begin
               par_ok = (tx === ^rx);
`endif
            end else if (pos == (NBITS - 1) * DIV + 2) begin
               frames_rx++;
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL frame_unexpected got=%02h expected=none", rx);
               end else begin
                  exp_b = sb.pop_front();
                  if (rx !== exp_b || tx !== 1'b1 || !par_ok) begin
                     errors++;
                     $display("FAIL frame got=%02h stop=%b par_ok=%b expected=%02h stop=1 par_ok=1",
                              rx, tx, par_ok, exp_b);
                  end
               end
               pos = -1;
               prev = tx;
            end
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(tx_busy === 1'b0 && empty === 1'b1 && sb.size() == 0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 2000) begin
         errors++;
         $display("FAIL wait_idle timeout busy=%b empty=%b pending=%0d expected idle",
                  tx_busy, empty, sb.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wr_en = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || empty !== 1'b1 || tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold tx=%b empty=%b busy=%b expected 1 1 0", tx, empty, tx_busy);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || empty !== 1'b1 || full !== 1'b0 || count !== 4'd0 ||
          tx_busy !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_state tx=%b empty=%b full=%b count=%0d busy=%b ovf=%b expected 1 1 0 0 0 0",
                  tx, empty, full, count, tx_busy, overflow);
      end
   endtask

   task automatic test_single_byte();
      wait_idle();
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = 8'hA5;
      sb.push_back(8'hA5);
      @(negedge clk);
      wr_en = 1'b0;
      checks++;
      if (empty !== 1'b0 || count !== 4'd1 || tx !== 1'b1) begin
         errors++;
         $display("FAIL write_latency empty=%b count=%0d tx=%b expected 0 1 1", empty, count, tx);
      end
      for (int c = 1; c <= FRAME; c++) begin
         @(negedge clk);
         checks++;
         if (tx !== tx_expect(8'hA5, c) || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL wave_a5 cycle=%0d tx=%b busy=%b expected tx=%b busy=1",
                     c, tx, tx_busy, tx_expect(8'hA5, c));
         end
      end
      @(negedge clk);
      checks++;
      if (tx_busy !== 1'b0 || tx !== 1'b1) begin
         errors++;
         $display("FAIL busy_fall busy=%b tx=%b expected 0 1", tx_busy, tx);
      end
   endtask

   task automatic test_overflow();
      int         pulses;
      int         f0;
      int         n;
      logic [3:0] peak;
      wait_idle();
      pulses = 0;
      peak = 4'd0;
      f0 = frames_rx;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (overflow === 1'b1) pulses++;
         if (count > peak) peak = count;
         wr_en = 1'b1;
         wr_data = 8'(8'h30 + i);
         if (i < 9) sb.push_back(8'(8'h30 + i));
      end
      @(negedge clk);
      wr_en = 1'b0;
      if (count > peak) peak = count;
      checks++;
      if (overflow !== 1'b1 || full !== 1'b1) begin
         errors++;
         $display("FAIL ovf_on_10th ovf=%b full=%b expected 1 1", overflow, full);
      end
      if (overflow === 1'b1) pulses++;
      repeat (3) begin
         @(negedge clk);
         if (overflow === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 1 || peak !== 4'd8) begin
         errors++;
         $display("FAIL ovf_pulse pulses=%0d peak=%0d expected 1 8", pulses, peak);
      end
      n = 0;
      while (sb.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      repeat (100) @(negedge clk);
      checks++;
      if (frames_rx - f0 != 9 || sb.size() != 0) begin
         errors++;
         $display("FAIL ovf_frames got=%0d pending=%0d expected 9 0", frames_rx - f0, sb.size());
      end
   endtask

   task automatic test_back_to_back();
      int n;
      int highs;
      wait_idle();
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = 8'h00;
      sb.push_back(8'h00);
      @(negedge clk);
      wr_data = 8'hFF;
      sb.push_back(8'hFF);
      @(negedge clk);
      wr_en = 1'b0;
      n = 0;
      while (tx !== 1'b1 && n < 80) begin
         @(negedge clk);
         n++;
      end
      highs = 0;
      while (tx === 1'b1 && highs < 20) begin
         highs++;
         @(negedge clk);
      end
      checks++;
      if (highs != DIV + 1 || n >= 80) begin
         errors++;
         $display("FAIL b2b_gap high_cycles=%0d expected %0d", highs, DIV + 1);
      end
      wait_idle();
   endtask

   task automatic test_reset_mid_frame();
      int bad;
      int f0;
      wait_idle();
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = 8'h55;
      sb.push_back(8'h55);
      @(negedge clk);
      wr_data = 8'h33;
      sb.push_back(8'h33);
      @(negedge clk);
      wr_en = 1'b0;
      checks++;
      if (tx !== 1'b0) begin
         errors++;
         $display("FAIL mid_start tx=%b expected 0", tx);
      end
      repeat (17) @(negedge clk);
      checks++;
      if (tx !== 1'b0) begin
         errors++;
         $display("FAIL mid_bit3 tx=%b expected 0", tx);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (tx !== 1'b1 || empty !== 1'b1 || count !== 4'd0 || tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset tx=%b empty=%b count=%0d busy=%b expected 1 1 0 0",
                  tx, empty, count, tx_busy);
      end
      sb.delete();
      f0 = frames_rx;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (tx !== 1'b1 || tx_busy !== 1'b0 || empty !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0 || frames_rx != f0) begin
         errors++;
         $display("FAIL post_reset_quiet bad_cycles=%0d frames=%0d expected 0 0",
                  bad, frames_rx - f0);
      end
   endtask

   task automatic test_parity_frame();
      int   busy_len;
      int   bad;
      logic exp_par;
`ifdef UART_TX_PARITY_EN
      exp_par = ^(8'h07);
`else
      exp_par = 1'b1;
`endif
      wait_idle();
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = 8'h07;
      sb.push_back(8'h07);
      @(negedge clk);
      wr_en = 1'b0;
      busy_len = 0;
      bad = 0;
      for (int c = 1; c <= 50; c++) begin
         @(negedge clk);
         if (tx_busy === 1'b1) busy_len++;
         if (c > 9 * DIV && c <= 10 * DIV && tx !== exp_par) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bit_after_d7 bad_cycles=%0d expected level %b", bad, exp_par);
      end
      checks++;
      if (busy_len != FRAME) begin
         errors++;
         $display("FAIL frame_len got=%0d expected %0d", busy_len, FRAME);
      end
      wait_idle();
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_overflow();
      test_back_to_back();
      test_parity_frame();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter for the SoC's uart0 peripheral; it sits directly upstream of the uart0_tx pin.
- The core writes bytes into a small FIFO through the peripheral register interface. A bit-timing FSM drains the FIFO and serialises each byte as 8N1 frames, LSB first, at a fixed baud rate.
- Single clock domain: the core clock.

Parameters:
- CLK_FREQ, 10_000_000, core clock frequency in Hz.
- BAUD, 9600, line rate in bits/s. DIVISOR = CLK_FREQ/BAUD, integer truncation; DIVISOR must be >= 2, otherwise elaboration fails via $error.
- FIFO_DEPTH, 8, number of FIFO entries. Must be a power of two and >= 2.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  enqueue request, sampled on the rising edge of clk.
- wr_data  input  8  byte to enqueue.
- full  output  1  FIFO holds FIFO_DEPTH entries (registered).
- empty  output  1  FIFO holds 0 entries (registered).
- count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy; excludes the byte currently being shifted.
- overflow  output  1  one-cycle pulse when a write is dropped.
- tx_busy  output  1  high whenever the FSM is not in IDLE.
- tx  output  1  serial line; idles high.

Behaviour:
- Reset (async assert, sync release):
  - tx=1, full=0, empty=1, count=0, overflow=0, tx_busy=0.
  - Read/write pointers=0, bit counter=0, baud counter=0, FSM=IDLE.
  - Reset mid-frame aborts the frame immediately: tx returns high while rst_n is low, and FIFO contents are discarded.
- Write:
  - wr_en && !full: wr_data is stored at the write pointer on the clock edge; count increments at that edge.
  - wr_en && full: the data is dropped and overflow pulses high for the next cycle only.
  - full is the registered value. A pop in the same cycle does not rescue a write issued while full.
- Pointer arithmetic: pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. count is tracked separately.
  - Write only: +1. Pop only: -1. Write and pop in the same cycle: unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if !empty, pop the head byte into an 8-bit shift register, clear the baud counter, go to START. Otherwise stay in IDLE. IDLE always lasts at least one cycle.
  - START: tx=0 for DIVISOR cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for DIVISOR cycles, then shift right and increment the bit index. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for DIVISOR cycles, then go to IDLE.
- tx is driven from a register, so the line carries no glitches.
- Latency:
  - Write accepted at edge N into an empty FIFO, FSM idle: empty deasserts at edge N.
  - The FSM pops at edge N+1 and tx falls at edge N+1. The start bit is visible from N+1.
- Back-to-back frames: the next start bit begins exactly one clock after the stop bit's DIVISOR cycles end (the IDLE cycle).
- Baud counter: counts 0..DIVISOR-1 and wraps to 0 at each bit boundary. Bit time is exactly DIVISOR clocks.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined: a PARITY state is inserted between DATA and STOP.
  - tx = XOR of the 8 data bits (even parity) for DIVISOR cycles.
  - Frame length is 11 bit times.
- When undefined: there is no PARITY state, frames are 8N1 (10 bit times), and no parity logic is synthesised.

Test Plan:
Configure CLK_FREQ=1_000_000 and BAUD=250_000, giving DIVISOR=4.
1. Reset: hold rst_n low 3 cycles, then release -> tx=1, empty=1, full=0, count=0, tx_busy=0, overflow=0.
2. Single byte: write 0xA5 at edge N.
   - tx=0 from N+1 for 4 clocks.
   - Then data bits 1,0,1,0,0,1,0,1, each 4 clocks.
   - Then stop=1 for 4 clocks; tx_busy falls at edge N+41.
3. Overflow: write 10 distinct bytes on consecutive cycles while idle.
   - count peaks at 8, full=1, overflow pulses once on the 10th write.
   - Exactly 9 frames appear on tx, in write order; the 10th byte is never sent.
4. Back-to-back: enqueue 0x00 and 0xFF -> the first stop bit ends and the second start bit begins after exactly one high clock, i.e. 5 consecutive tx=1 cycles.
5. Reset mid-frame: enqueue 0x55 and 0x33, then drop rst_n during data bit 3.
   - tx=1 asynchronously and empty=1.
   - After release, no frame is emitted for 100 cycles.
6. With UART_TX_PARITY_EN: write 0x07 -> the parity bit is 1 for 4 clocks after data bit 7, then stop; the frame spans 44 clocks. Without the macro, the same write gives a 40-clock frame.
